// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the alu_sched front end and the alu it drives.
package alu_sched_pkg;

    localparam int DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } sched_state_t;

    localparam logic [1:0] W8  = 2'd0;
    localparam logic [1:0] W16 = 2'd1;
    localparam logic [1:0] W32 = 2'd2;
    localparam logic [1:0] W64 = 2'd3;

    localparam logic [7:0] ALU_OP_ADD = 8'h01;
    localparam logic [7:0] ALU_OP_SUB = 8'h02;
    localparam logic [7:0] ALU_OP_AND = 8'h03;
    localparam logic [7:0] ALU_OP_XOR = 8'h04;
    localparam logic [7:0] ALU_OP_CMP = 8'h05;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [7:0]        op;
        logic [1:0]        width;
        logic              use_carry;
    } alu_req_t;

endpackage

// File: rtl/alu.sv
// Shared combinational ALU: add/sub/and/xor/compare on the low 8/16/32/64 bits.
// carry is carry-out for ADD and borrow for SUB/CMP; CMP updates flags only (setr=0).
module alu
    import alu_sched_pkg::*;
#(
    parameter int XLEN = DATA_W
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [7:0]      op,
    input  logic [1:0]      width,
    input  logic            cin,
    output logic [XLEN-1:0] r,
    output logic            zero,
    output logic            carry,
    output logic            setcarry,
    output logic            setr
);

    logic [XLEN-1:0] mask;
    logic [XLEN-1:0] am;
    logic [XLEN-1:0] bm;
    logic [XLEN:0]   sum;
    logic [XLEN:0]   diff;

    always_comb begin
        case (width)
            W8:      mask = XLEN'(8'hFF);
            W16:     mask = XLEN'(16'hFFFF);
            W32:     mask = XLEN'(32'hFFFF_FFFF);
            default: mask = '1;
        endcase
        am   = a & mask;
        bm   = b & mask;
        sum  = {1'b0, am} + {1'b0, bm} + {{XLEN{1'b0}}, cin};
        diff = {1'b0, am} - {1'b0, bm} - {{XLEN{1'b0}}, cin};

        r        = '0;
        carry    = 1'b0;
        setcarry = 1'b0;
        setr     = 1'b0;
        // Any bit above the active width in sum/diff means carry-out or borrow.
        case (op)
            ALU_OP_ADD: begin
                r        = sum[XLEN-1:0] & mask;
                carry    = |(sum & ~{1'b0, mask});
                setcarry = 1'b1;
                setr     = 1'b1;
            end
            ALU_OP_SUB: begin
                r        = diff[XLEN-1:0] & mask;
                carry    = |(diff & ~{1'b0, mask});
                setcarry = 1'b1;
                setr     = 1'b1;
            end
            ALU_OP_AND: begin
                r    = am & bm;
                setr = 1'b1;
            end
            ALU_OP_XOR: begin
                r    = am ^ bm;
                setr = 1'b1;
            end
            ALU_OP_CMP: begin
                r        = diff[XLEN-1:0] & mask;
                carry    = |(diff & ~{1'b0, mask});
                setcarry = 1'b1;
            end
            default: ;
        endcase
        zero = (r == '0);
    end

endmodule

// File: rtl/alu_sched.sv
// alu_sched: round-robin two-requester scheduler in front of the shared alu, tagged response.
// Per-requester carry/zero flags and carry chaining exist only with ALU_SCHED_FLAGS_EN defined.
module alu_sched
    import alu_sched_pkg::*;
#(
    parameter int XLEN = DATA_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [1:0][XLEN-1:0] req_a,
    input  logic [1:0][XLEN-1:0] req_b,
    input  logic [1:0][7:0]      req_op,
    input  logic [1:0][1:0]      req_width,
    input  logic [1:0]           req_use_carry,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [XLEN-1:0]      rsp_r,
    output logic                 rsp_zero,
    output logic                 rsp_carry,
    output logic [1:0]           flag_carry,
    output logic [1:0]           flag_zero
);

    sched_state_t    state, state_next;
    alu_req_t        cur;
    logic            cur_id;
    logic            last_grant;
    logic            grant;
    logic            accept;
    logic            cin;
    logic [XLEN-1:0] alu_r;
    logic            alu_zero, alu_carry, alu_setcarry, alu_setr;

    // On a tie the requester that did not win last time gets the slot.
    assign grant     = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
    assign rsp_valid = (state == RESP);

    always_comb begin
        state_next = state;
        req_ready  = 2'b00;
        accept     = 1'b0;
        unique case (state)
            IDLE: begin
                if (rst_n && (req_valid != 2'b00)) begin
                    req_ready  = grant ? 2'b10 : 2'b01;
                    accept     = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC:    state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur        <= '0;
            cur_id     <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept) begin
            cur.a         <= req_a[grant];
            cur.b         <= req_b[grant];
            cur.op        <= req_op[grant];
            cur.width     <= req_width[grant];
            cur.use_carry <= req_use_carry[grant];
            cur_id        <= grant;
            last_grant    <= grant;
        end
    end

    alu #(.XLEN(XLEN)) u_alu (
        .a        (cur.a),
        .b        (cur.b),
        .op       (cur.op),
        .width    (cur.width),
        .cin      (cin),
        .r        (alu_r),
        .zero     (alu_zero),
        .carry    (alu_carry),
        .setcarry (alu_setcarry),
        .setr     (alu_setr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_id    <= 1'b0;
            rsp_r     <= '0;
            rsp_zero  <= 1'b0;
            rsp_carry <= 1'b0;
        end else if (state == EXEC) begin
            rsp_id    <= cur_id;
            rsp_r     <= alu_setr ? alu_r : '0;
            rsp_zero  <= alu_zero;
            rsp_carry <= alu_carry;
        end
    end

`ifdef ALU_SCHED_FLAGS_EN
    logic [1:0] carry_q, zero_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= 2'b00;
            zero_q  <= 2'b00;
        end else if (state == EXEC) begin
            if (alu_setcarry) carry_q[cur_id] <= alu_carry;
            if (alu_setr)     zero_q[cur_id]  <= alu_zero;
        end
    end

    assign cin        = cur.use_carry & carry_q[cur_id];
    assign flag_carry = carry_q;
    assign flag_zero  = zero_q;
`else
    logic unused_flags;
    assign unused_flags = ^{cur.use_carry, alu_setcarry};
    assign cin          = 1'b0;
    assign flag_carry   = 2'b00;
    assign flag_zero    = 2'b00;
`endif

endmodule

// File: tb/tb_alu_sched.sv
// Randomized and directed bench for alu_sched against a transaction-level reference model.
// Flag expectations follow ALU_SCHED_FLAGS_EN when it is defined for the build.
module tb_alu_sched;

`ifdef ALU_SCHED_FLAGS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [1:0]        req_valid = 2'b00;
    logic [1:0]        req_ready;
    logic [1:0][63:0]  req_a = '0;
    logic [1:0][63:0]  req_b = '0;
    logic [1:0][7:0]   req_op = '0;
    logic [1:0][1:0]   req_width = '0;
    logic [1:0]        req_use_carry = 2'b00;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic              rsp_id;
    logic [63:0]       rsp_r;
    logic              rsp_zero, rsp_carry;
    logic [1:0]        flag_carry, flag_zero;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state: one outstanding op, its age in cycles, and its predicted result
    bit          m_busy;
    int          m_age;
    bit          m_last;
    bit [1:0]    m_fc, m_fz;
    bit          m_id, m_z, m_c, m_sc, m_sr;
    logic [63:0] m_r;
    int          dut_grants[$];

    alu_sched dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_op        (req_op),
        .req_width     (req_width),
        .req_use_carry (req_use_carry),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_r         (rsp_r),
        .rsp_zero      (rsp_zero),
        .rsp_carry     (rsp_carry),
        .flag_carry    (flag_carry),
        .flag_zero     (flag_zero)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Plain-arithmetic ALU: operate on the low n bits, carry/borrow from the 65-bit result.
    function automatic void aluModel(input logic [63:0] a, input logic [63:0] b, input logic [7:0] op,
                                     input logic [1:0] w, input bit cin, output logic [63:0] r,
                                     output bit z, output bit c, output bit sc, output bit sr);
        int n;
        logic [64:0] m, am, bm, t;
        n  = 8 << w;
        m  = (65'd1 << n) - 65'd1;
        am = {1'b0, a} & m;
        bm = {1'b0, b} & m;
        r = '0; c = 0; sc = 0; sr = 0;
        t = '0;
        case (op)
            8'h01: begin t = am + bm + 65'(cin); c = t[n]; sc = 1; sr = 1; end
            8'h02: begin t = am - bm - 65'(cin); c = (am < bm + 65'(cin)); sc = 1; sr = 1; end
            8'h03: begin t = am & bm; sr = 1; end
            8'h04: begin t = am ^ bm; sr = 1; end
            8'h05: begin t = am - bm - 65'(cin); c = (am < bm + 65'(cin)); sc = 1; end
            default: ;
        endcase
        z = ((t & m) == 65'd0);
        if (sr) r = t[63:0] & m[63:0];
    endfunction

    task automatic resetModel();
        m_busy = 0; m_age = 0; m_last = 1; m_fc = 2'b00; m_fz = 2'b00;
    endtask

    task automatic setOp(input int id, input logic [63:0] a, input logic [63:0] b, input logic [7:0] op,
                         input logic [1:0] w, input logic uc);
        req_a[id] = a; req_b[id] = b; req_op[id] = op; req_width[id] = w; req_use_carry[id] = uc;
    endtask

    // Drive one cycle of requests, check every output against the model, then advance one edge.
    task automatic applyStimulus(input logic [1:0] v, input logic rr);
        bit g, gv, cin;
        logic [1:0] er;
        req_valid = v;
        rsp_ready = rr;
        #1;
        gv = !m_busy && (v != 2'b00);
        g  = (v == 2'b11) ? ~m_last : v[1];
        er = gv ? (g ? 2'b10 : 2'b01) : 2'b00;
        checkOutput("req_ready", req_ready, er);
        if (req_ready != 2'b00) dut_grants.push_back(int'(req_ready[1]));
        checkOutput("rsp_valid", rsp_valid, m_busy && m_age >= 2);
        if (m_busy && m_age >= 2) begin
            checkOutput("rsp_id", rsp_id, m_id);
            checkOutput("rsp_r", rsp_r, m_r);
            checkOutput("rsp_zero", rsp_zero, m_z);
            checkOutput("rsp_carry", rsp_carry, m_c);
        end
        checkOutput("flag_carry", flag_carry, FLAGS_EN ? m_fc : 2'b00);
        checkOutput("flag_zero", flag_zero, FLAGS_EN ? m_fz : 2'b00);
        @(posedge clk);
        #1;
        if (m_busy) begin
            if (m_age >= 2 && rr) m_busy = 0;
            else if (m_age == 1) begin
                m_age = 2;
                if (m_sc) m_fc[m_id] = m_c;
                if (m_sr) m_fz[m_id] = m_z;
            end
        end else if (gv) begin
            cin = FLAGS_EN && req_use_carry[g] && m_fc[g];
            aluModel(req_a[g], req_b[g], req_op[g], req_width[g], cin, m_r, m_z, m_c, m_sc, m_sr);
            m_id = g; m_last = g; m_busy = 1; m_age = 1;
        end
    endtask

    initial begin
        int exp_seq[4];
        logic [1:0] rv;
        exp_seq = '{0, 1, 0, 1};
        resetModel();

        // reset with both requesters valid
        setOp(0, 64'h10, 64'h20, 8'h01, 2'd1, 1'b0);
        setOp(1, 64'h05, 64'h03, 8'h02, 2'd2, 1'b0);
        req_valid = 2'b11;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_req_ready", req_ready, 2'b00);
        checkOutput("reset_rsp_valid", rsp_valid, 1'b0);
        checkOutput("reset_rsp_r", rsp_r, 64'h0);
        checkOutput("reset_flags", {flag_carry, flag_zero}, 4'h0);
        rst_n = 1'b1;

        // four back-to-back ops with both valid: grants must alternate from 0
        dut_grants.delete();
        applyStimulus(2'b11, 1'b1);
        applyStimulus(2'b11, 1'b1);
        checkOutput("first_rsp_id", rsp_id, 1'b0);
        repeat (10) applyStimulus(2'b11, 1'b1);
        checkOutput("grant_count", dut_grants.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < dut_grants.size()) checkOutput("grant_seq", dut_grants[i], exp_seq[i]);

        // req0 8-bit ADD A8+22
        setOp(0, 64'hA8, 64'h22, 8'h01, 2'd0, 1'b0);
        applyStimulus(2'b01, 1'b1);
        checkOutput("add_exec_no_valid", rsp_valid, 1'b0);
        applyStimulus(2'b00, 1'b1);
        checkOutput("add_valid", rsp_valid, 1'b1);
        checkOutput("add_r", rsp_r, 64'hCA);
        checkOutput("add_carry", rsp_carry, 1'b0);
        checkOutput("add_zero", rsp_zero, 1'b0);
        applyStimulus(2'b00, 1'b1);

        // req1 carry chain: FF+01 then 0+0+cin
        setOp(1, 64'hFF, 64'h01, 8'h01, 2'd0, 1'b0);
        applyStimulus(2'b10, 1'b1);
        applyStimulus(2'b00, 1'b1);
        checkOutput("chain1_carry", rsp_carry, 1'b1);
        checkOutput("chain1_r", rsp_r, 64'h0);
        checkOutput("chain1_zero", rsp_zero, 1'b1);
        checkOutput("chain1_flag1", flag_carry[1], FLAGS_EN);
        checkOutput("chain1_flag0", flag_carry[0], 1'b0);
        applyStimulus(2'b00, 1'b1);
        setOp(1, 64'h0, 64'h0, 8'h01, 2'd0, 1'b1);
        applyStimulus(2'b10, 1'b1);
        applyStimulus(2'b00, 1'b1);
        checkOutput("chain2_r", rsp_r, FLAGS_EN ? 64'h1 : 64'h0);
        checkOutput("chain2_flag0", flag_carry[0], 1'b0);
        applyStimulus(2'b00, 1'b1);

        // backpressure: response held for 5 cycles with both requesters waiting
        setOp(0, 64'h1234, 64'h00FF, 8'h04, 2'd1, 1'b0);
        applyStimulus(2'b01, 1'b0);
        applyStimulus(2'b00, 1'b0);
        repeat (5) applyStimulus(2'b11, 1'b0);
        applyStimulus(2'b11, 1'b1);
        applyStimulus(2'b11, 1'b1);
        repeat (3) applyStimulus(2'b00, 1'b1);

        // reset asserted during EXEC discards the operation
        setOp(0, 64'h7, 64'h9, 8'h01, 2'd3, 1'b0);
        applyStimulus(2'b01, 1'b1);
        req_valid = 2'b00;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_req_ready", req_ready, 2'b00);
        checkOutput("midrst_rsp", {rsp_valid, rsp_id, rsp_zero, rsp_carry}, 4'h0);
        checkOutput("midrst_rsp_r", rsp_r, 64'h0);
        checkOutput("midrst_flags", {flag_carry, flag_zero}, 4'h0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("midrst_no_rsp", rsp_valid, 1'b0);
        rst_n = 1'b1;
        resetModel();
        applyStimulus(2'b00, 1'b1);
        checkOutput("postrst_no_rsp", rsp_valid, 1'b0);
        applyStimulus(2'b01, 1'b1);
        applyStimulus(2'b00, 1'b1);
        checkOutput("postrst_r", rsp_r, 64'h10);
        applyStimulus(2'b00, 1'b1);

        // randomized traffic
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int id = 0; id < 2; id++) begin
                setOp(id,
                      ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 255)) : {$urandom, $urandom},
                      ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 255)) : {$urandom, $urandom},
                      8'($urandom_range(1, 5)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            end
            rv = 2'($urandom_range(0, 3));
            applyStimulus(rv, $urandom_range(0, 3) != 0);
        end
        repeat (4) applyStimulus(2'b00, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_sched.md
# alu_sched

Two-requester scheduler for the shared 64-bit combinational `alu`.
- Accepts operations from two requesters over valid/ready channels and arbitrates round-robin.
- Registers operands and drives the ALU, then returns the result plus flags on a single tagged response channel.
- Keeps a per-requester carry/zero flag pair so multi-word arithmetic from each requester chains through `cin`.
- Sits between the issue logic and the ALU.

## Interface
- `XLEN`, 64: operand/result width (must match `alu`)
- `clk` in 1: clock, all state on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `req_valid` in 2: per-requester operation valid
- `req_ready` out 2: per-requester accept
- `req_a`, `req_b` in 2×XLEN: operands
- `req_op` in 2×8: ALU opcode
- `req_width` in 2×2: ALU width code, passed to `alu` unmodified
- `req_use_carry` in 2: drive `cin` from the requester's carry flag (else `cin`=0)
- `rsp_valid` out 1: result available
- `rsp_ready` in 1: consumer accepts result
- `rsp_id` out 1: requester index of result
- `rsp_r` out XLEN: ALU result (0 when ALU `setr`=0)
- `rsp_zero`, `rsp_carry` out 1: ALU zero/carry of this op
- `flag_carry`, `flag_zero` out 2: architectural flag registers per requester

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state IDLE.
- IDLE: grant = requester with `req_valid`. If both are valid, grant the one not granted last.
  - `last_grant` resets to 1, so requester 0 wins the first tie.
  - `req_ready[i]` = IDLE & grant==i. It is combinational from `req_valid`; requesters must not make valid depend on ready.
  - On handshake: latch a, b, op, width, use_carry and id; update `last_grant`; go to EXEC.
- EXEC: latched operands drive `alu`. `cin` = use_carry ? flag_carry[id] : 0.
  - Capture r, zero, carry, setcarry and setr into the response register.
  - Update flags for `id`:
    - flag_carry ← carry if setcarry.
    - flag_zero ← zero if setr.
  - Go to RESP.
- RESP: `rsp_valid`=1. All `rsp_*` hold stable until `rsp_ready`; then go to IDLE.
  - No new request is accepted in the cycle `rsp_ready` is seen.
- Only one operation is in flight. `req_ready` is 0 in EXEC and RESP.
- Reset mid-operation: the in-flight op is discarded and no response is produced.
- Reset values:
  - `rsp_valid`=0, `rsp_id`=0, `rsp_r`=0, `rsp_zero`=0, `rsp_carry`=0.
  - `flag_carry`=0, `flag_zero`=0.
  - `req_ready`=0 during reset. In IDLE it then follows the grant rule.

## Timing
- Handshake at edge N. EXEC during cycle N+1. `rsp_valid` high from cycle N+2.
- `rsp_ready` high in cycle N+2: response is consumed at that edge. Next accept possible at edge N+3.
- Throughput: one op per 3 cycles with no backpressure.
- Flag update is visible on `flag_*` from cycle N+2. A back-to-back op from the same requester sees the updated carry.
- `rsp_ready` held low: RESP persists indefinitely, outputs unchanged.

## Configuration
- `ALU_SCHED_FLAGS_EN` defined:
  - Per-requester flag registers are present.
  - `req_use_carry` selects `cin`.
  - `flag_*` outputs are live.
- Undefined:
  - No flag registers.
  - `cin` tied 0 and `req_use_carry` ignored.
  - `flag_carry`/`flag_zero` tied 0.
  - `rsp_zero`/`rsp_carry` still report the ALU outputs.

## Structure
- Package `alu_sched_pkg` holds:
  - `sched_state_t` enum (IDLE, EXEC, RESP).
  - Width codes `W8`/`W16`/`W32`/`W64` = 0..3.
  - `alu_req_t` struct {a, b, op, width, use_carry}.
  - `ALU_OP_ADD` = 8'h01.
- Sub-module: the existing `alu`, instantiated once and driven from the operand register.
- The round-robin arbiter is inline logic, not a separate module.

## Test plan
- Reset with both requesters valid:
  - During `rst_n`=0: `req_ready`=0 and `rsp_valid`=0.
  - After release: requester 0 granted first, `rsp_id`=0.
- Req0 ADD, a=64'hA8, b=64'h22, width=0, `rsp_ready`=1:
  - `rsp_valid` exactly 2 cycles after handshake.
  - `rsp_r`=64'hCA, `rsp_carry`=0, `rsp_zero`=0.
- Both requesters valid continuously for 4 ops:
  - Grant sequence is 0,1,0,1.
  - Each `rsp_id` matches its requester's operands.
- Req1 ADD a=64'hFF, b=64'h01, width=0, then ADD a=0, b=0 with use_carry=1:
  - First response: carry=1, r=0, zero=1. `flag_carry[1]`=1.
  - Second response: r=1.
  - `flag_carry[0]` remains 0 throughout.
- Hold `rsp_ready`=0 for 5 cycles after a response:
  - `rsp_*` stable, `req_ready`=0 throughout.
  - Accept occurs the cycle after `rsp_ready` rises.
- Assert `rst_n`=0 during EXEC:
  - All outputs return to reset values and no response appears.
  - Next request completes normally.
